// File: rtl/hash_stream_io.sv
// Stream front/back end for the hash core: packs input words into a message block
// and serialises a digest into output beats. Input and output sides are independent.
module hash_stream_io #(
  parameter int IN_W     = 8,
  parameter int BLOCK_W  = 512,
  parameter int DIGEST_W = 160,
  parameter int OUT_W    = 16,
  localparam int WORDS_IN  = BLOCK_W / IN_W,
  localparam int LEN_W     = $clog2(WORDS_IN) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  input  logic [IN_W-1:0]     i_text,
  input  logic                i_last,
  output logic                o_in_ready,
  output logic [BLOCK_W-1:0]  o_block,
  output logic [LEN_W-1:0]    o_block_len,
  output logic                o_block_valid,
  input  logic                i_block_ack,
  input  logic [DIGEST_W-1:0] i_digest,
  input  logic                i_digest_valid,
  output logic                o_digest_ready,
  output logic [OUT_W-1:0]    o_answer,
  output logic                o_valid,
  output logic                o_last,
  input  logic                i_out_ready
);
  localparam int WORDS_OUT = DIGEST_W / OUT_W;
  localparam int BEAT_W    = $clog2(WORDS_OUT + 1);

  typedef enum logic {COLLECT, HOLD} in_state_e;
  typedef enum logic {IDLE, SEND} out_state_e;

  in_state_e           in_state_q, in_state_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [BLOCK_W-1:0]  block_q, block_d;
  out_state_e          out_state_q, out_state_d;
  logic [DIGEST_W-1:0] shift_q, shift_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_state_q  <= COLLECT;
      cnt_q       <= '0;
      block_q     <= '0;
      out_state_q <= IDLE;
      shift_q     <= '0;
      beat_q      <= '0;
    end else begin
      in_state_q  <= in_state_d;
      cnt_q       <= cnt_d;
      block_q     <= block_d;
      out_state_q <= out_state_d;
      shift_q     <= shift_d;
      beat_q      <= beat_d;
    end
  end

  // Input side: cnt doubles as the reported length once the block is held.
  always_comb begin
    in_state_d = in_state_q;
    cnt_d      = cnt_q;
    block_d    = block_q;
    case (in_state_q)
      COLLECT: begin
        if (i_valid) begin
          for (int i = 0; i < WORDS_IN; i++) begin
            if (cnt_q == LEN_W'(i)) block_d[BLOCK_W-1-i*IN_W -: IN_W] = i_text;
          end
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == LEN_W'(WORDS_IN - 1) || i_last) in_state_d = HOLD;
        end
      end
      HOLD: begin
        if (i_block_ack) begin
          in_state_d = COLLECT;
          cnt_d      = '0;
          block_d    = '0;
        end
      end
      default: in_state_d = COLLECT;
    endcase
  end

  // Output side: the shift register is cleared after the last beat so o_answer idles at 0.
  always_comb begin
    out_state_d = out_state_q;
    shift_d     = shift_q;
    beat_d      = beat_q;
    case (out_state_q)
      IDLE: begin
        if (i_digest_valid) begin
          shift_d     = i_digest;
          beat_d      = '0;
          out_state_d = SEND;
        end
      end
      SEND: begin
        if (i_out_ready) begin
          if (beat_q == BEAT_W'(WORDS_OUT - 1)) begin
            shift_d     = '0;
            beat_d      = '0;
            out_state_d = IDLE;
          end else begin
            shift_d = shift_q << OUT_W;
            beat_d  = beat_q + BEAT_W'(1);
          end
        end
      end
      default: out_state_d = IDLE;
    endcase
  end

  always_comb begin
    o_in_ready     = (in_state_q == COLLECT);
    o_block_valid  = (in_state_q == HOLD);
    o_block        = block_q;
    o_block_len    = (in_state_q == HOLD) ? cnt_q : '0;
    o_digest_ready = (out_state_q == IDLE);
    o_valid        = (out_state_q == SEND);
    o_answer       = shift_q[DIGEST_W-1 -: OUT_W];
    o_last         = (out_state_q == SEND) && (beat_q == BEAT_W'(WORDS_OUT - 1));
  end
endmodule
